// File: rtl/gpio_tlul_target.sv
// ============================================================================
// gpio_tlul_target : TL-UL device responder for a small GPIO register file
// Revision 1.0
// ============================================================================
`default_nettype none

package tlul_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module gpio_tlul_target #(
  parameter int          GPIO_WIDTH = 32,
  parameter logic [31:0] ADDR_BASE  = 32'h0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  tlul_pkg::tl_h2d_t       tl_i,
  output tlul_pkg::tl_d2h_t       tl_o,
  input  logic [GPIO_WIDTH-1:0]   gpio_i,
  output logic [GPIO_WIDTH-1:0]   gpio_o,
  output logic [GPIO_WIDTH-1:0]   gpio_oe_o,
  output logic                    intr_o
);
  localparam logic [31:0] REG_MASK    = 32'((64'd1 << GPIO_WIDTH) - 64'd1);
  localparam logic [2:0]  OP_PUT_FULL = 3'd0;
  localparam logic [2:0]  OP_PUT_PART = 3'd1;
  localparam logic [2:0]  OP_GET      = 3'd4;
  localparam logic [2:0]  D_ACK       = 3'd0;
  localparam logic [2:0]  D_ACK_DATA  = 3'd1;
  localparam logic [4:0]  OFS_DATA_IN = 5'h00;
  localparam logic [4:0]  OFS_DATA_OUT = 5'h04;
  localparam logic [4:0]  OFS_DIR     = 5'h08;
  localparam logic [4:0]  OFS_ISTATE  = 5'h0C;
  localparam logic [4:0]  OFS_IENABLE = 5'h10;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;
  state_t state, state_next;

  logic [GPIO_WIDTH-1:0] sync1, sync2, sync2_prev;
  logic [31:0] data_out, dir, intr_state, intr_enable;
  logic [31:0] addr_rel, byte_mask, wdata, rdata, data_in, rise, clear;
  logic [4:0]  offset;
  logic        is_get, is_put, err, accept, wr_en;
  logic [7:0]  rsp_source;
  logic [1:0]  rsp_size;
  logic        rsp_read, rsp_error;
  logic [31:0] rsp_data;
  logic        unused_bits;

  assign addr_rel = tl_i.a_address - ADDR_BASE;
  assign offset   = addr_rel[4:0];
  assign is_get   = (tl_i.a_opcode == OP_GET);
  assign is_put   = (tl_i.a_opcode == OP_PUT_FULL) || (tl_i.a_opcode == OP_PUT_PART);
  assign err      = !(is_get || is_put) || (tl_i.a_size != 2'd2) ||
                    (tl_i.a_address[1:0] != 2'b00) || (offset > OFS_IENABLE) ||
                    (is_put && offset == OFS_DATA_IN);
  assign accept   = (state == IDLE) && tl_i.a_valid;
  assign wr_en    = accept && is_put && !err;

  assign byte_mask = {{8{tl_i.a_mask[3]}}, {8{tl_i.a_mask[2]}},
                      {8{tl_i.a_mask[1]}}, {8{tl_i.a_mask[0]}}} & REG_MASK;
  assign wdata     = tl_i.a_data & byte_mask;
  assign data_in   = 32'(sync2);
  assign rise      = 32'(sync2 & ~sync2_prev);
  assign clear     = (wr_en && offset == OFS_ISTATE) ? wdata : 32'h0;
  assign unused_bits = ^{addr_rel[31:5], tl_i.a_param, tl_i.a_user};

  always_comb begin
    rdata = 32'h0;
    case (offset)
      OFS_DATA_IN:  rdata = data_in;
      OFS_DATA_OUT: rdata = data_out;
      OFS_DIR:      rdata = dir;
      OFS_ISTATE:   rdata = intr_state;
      OFS_IENABLE:  rdata = intr_enable;
      default:      rdata = 32'h0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tl_i.a_valid) state_next = RESP;
      RESP:    if (tl_i.d_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      sync1       <= '0;
      sync2       <= '0;
      sync2_prev  <= '0;
      data_out    <= 32'h0;
      dir         <= 32'h0;
      intr_state  <= 32'h0;
      intr_enable <= 32'h0;
      rsp_source  <= 8'h0;
      rsp_size    <= 2'd0;
      rsp_read    <= 1'b0;
      rsp_error   <= 1'b0;
      rsp_data    <= 32'h0;
    end else begin
      state      <= state_next;
      sync1      <= gpio_i;
      sync2      <= sync1;
      sync2_prev <= sync2;
      if (accept) begin
        rsp_source <= tl_i.a_source;
        rsp_size   <= tl_i.a_size;
        rsp_read   <= is_get;
        rsp_error  <= err;
        rsp_data   <= (is_get && !err) ? rdata : 32'h0;
      end
      if (wr_en && offset == OFS_DATA_OUT) data_out    <= (data_out & ~byte_mask) | wdata;
      if (wr_en && offset == OFS_DIR)      dir         <= (dir & ~byte_mask) | wdata;
      if (wr_en && offset == OFS_IENABLE)  intr_enable <= (intr_enable & ~byte_mask) | wdata;
      // a rising edge in the same cycle as a clear keeps the bit set
      intr_state <= (intr_state & ~clear) | rise;
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.a_ready  = (state == IDLE);
    tl_o.d_valid  = (state == RESP);
    tl_o.d_opcode = rsp_read ? D_ACK_DATA : D_ACK;
    tl_o.d_size   = rsp_size;
    tl_o.d_source = rsp_source;
    tl_o.d_data   = rsp_data;
    tl_o.d_error  = rsp_error;
  end

  assign gpio_o    = data_out[GPIO_WIDTH-1:0];
  assign gpio_oe_o = dir[GPIO_WIDTH-1:0];
  assign intr_o    = |(intr_state & intr_enable);
endmodule

`default_nettype wire

// File: doc/gpio_tlul_target.md
Name: gpio_tlul_target

Overview:
- TL-UL device-side responder for the GPIO peripheral. It terminates the host-to-device TL-UL link coming out of the peripheral crossbar.
- It decodes A-channel Get, PutFullData and PutPartialData requests into a small GPIO register file. It returns exactly one D-channel response per accepted request.
- It drives the GPIO output and output-enable pins, double-flop synchronises the input pins, and raises a level interrupt on input rising edges.

Parameters:
- GPIO_WIDTH, 32, number of GPIO pins (1..32); register bits at and above GPIO_WIDTH read 0 and ignore writes.
- ADDR_BASE, 32'h0, base address subtracted before decode; the offset is a_address[4:0].

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  synchronous active-low reset
- tl_i  input  tlul_pkg::tl_h2d_t  A channel and d_ready from the crossbar
- tl_o  output  tlul_pkg::tl_d2h_t  D channel and a_ready to the crossbar
- gpio_i  input  GPIO_WIDTH  asynchronous input pins
- gpio_o  output  GPIO_WIDTH  output pin values
- gpio_oe_o  output  GPIO_WIDTH  output enables (1 = drive)
- intr_o  output  1  interrupt, equal to OR(INTR_STATE & INTR_ENABLE)

Behaviour:
- Reset (rst_ni low at a clk_i edge): state=IDLE, all registers 0, synchroniser flops 0, d_valid=0, a_ready=1, gpio_o=0, gpio_oe_o=0, intr_o=0.
- Register map (word offsets):
  - 0x00 DATA_IN: RO, second synchroniser stage.
  - 0x04 DATA_OUT: RW, drives gpio_o.
  - 0x08 DIR: RW, drives gpio_oe_o.
  - 0x0C INTR_STATE: RW1C.
  - 0x10 INTR_ENABLE: RW.
- FSM has two states, IDLE and RESP.
- a_ready = (state==IDLE). It is combinational from state only, never from a_valid.
- Accept occurs when a_valid && a_ready in IDLE. At that clock edge:
  - capture d_source=a_source, d_size=a_size, the opcode class and the error flag;
  - perform the write, or latch the read data;
  - state goes to RESP.
- In RESP: d_valid=1 and all D fields stay stable until d_valid && d_ready. At that edge state returns to IDLE. A new request is accepted no earlier than the following cycle.
- Latency and throughput:
  - d_valid is asserted the cycle after accept when d_ready is already high.
  - Maximum throughput is one transaction per 2 cycles.
- Response fields:
  - Get returns d_opcode=AccessAckData (1) with the register value in d_data.
  - Put* returns d_opcode=AccessAck (0) with d_data=0.
  - d_param=0, d_sink=0, d_user=0.
- Error (d_error=1) is raised on any of:
  - a_opcode not in {0,1,4};
  - a_size != 2;
  - a_address[1:0] != 0;
  - offset > 0x10;
  - a write to DATA_IN.
- On error: no register changes, d_data=0. The d_opcode follows the request class, and an illegal opcode responds AccessAck.
- Writes apply byte-wise per a_mask. PutFullData uses a_mask as given.
- INTR_STATE update:
  - write-1-clears on masked bytes;
  - is set by a rising edge (sync stage 2 high, previous stage-2 sample low);
  - set wins over a simultaneous clear on the same bit.
- Inputs are sampled continuously, independent of the bus. Edge detection works whether or not a transaction is in progress.
- Reset mid-transaction (RESP, d_ready low): the response is dropped, d_valid=0 next cycle, and a_ready=1.
- DATA_OUT, DIR and INTR_ENABLE values are readable back exactly as written, masked to GPIO_WIDTH.

Test Plan:
- Reset then idle: a_ready=1, d_valid=0, gpio_o=0, gpio_oe_o=0, intr_o=0.
- PutFullData addr 0x04, data 32'hA5A5_0F0F, mask 4'hF, d_ready=1:
  - d_valid one cycle after accept, AccessAck, d_error=0, d_source echoed;
  - gpio_o=32'hA5A5_0F0F;
  - a following Get of 0x04 returns AccessAckData with d_data=32'hA5A5_0F0F.
- PutPartialData 0x08, data 32'hFFFF_FFFF, mask 4'b0010 -> gpio_oe_o=32'h0000_FF00.
- d_ready held low 5 cycles after a Get:
  - d_valid and d_data stay stable, a_ready=0 throughout;
  - a second a_valid is not accepted until the cycle after d_ready=1.
- Error cases, each returning d_error=1 with no state change:
  - Get at 0x14;
  - Put at 0x02;
  - a_size=1;
  - opcode 3'd5;
  - Put to 0x00.
- Interrupt path:
  - INTR_ENABLE=1, gpio_i[0] driven 0->1 -> INTR_STATE[0]=1 three cycles later and intr_o=1;
  - write 1 to 0x0C clears it and intr_o=0;
  - a clear that coincides with a new edge leaves the bit set.
